// File: rtl/spi_2_req_sched.sv
// Round-robin scheduler sharing one SPI master engine among NREQ requesters.
// One transaction in flight at a time: grant, start/done handshake with the master, respond.
module spi_2_req_sched #(
  parameter int NREQ         = 3,
  parameter int NSLAVES      = 4,
  parameter int S_ADDR_WIDTH = $clog2(NSLAVES),
  parameter int DWIDTH       = 32,
  parameter int AWIDTH       = 12,
  parameter int TIMEOUT      = 1023
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ-1:0]              req_rw,
  input  logic [NREQ*S_ADDR_WIDTH-1:0] req_sid,
  input  logic [NREQ*AWIDTH-1:0]       req_addr,
  input  logic [NREQ*DWIDTH-1:0]       req_wdata,
  output logic [NREQ-1:0]              rsp_valid,
  output logic [DWIDTH-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic                         m_start,
  output logic                         m_rw,
  output logic [S_ADDR_WIDTH-1:0]      m_sid,
  output logic [AWIDTH-1:0]            m_addr,
  output logic [DWIDTH-1:0]            m_wdata,
  input  logic                         m_done,
  input  logic [DWIDTH-1:0]            m_rdata,
  output logic                         busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           last_q, last_d, grant_q, grant_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    rw_q, rw_d, err_q, err_d;
  logic [S_ADDR_WIDTH-1:0] sid_q, sid_d;
  logic [AWIDTH-1:0]       addr_q, addr_d;
  logic [DWIDTH-1:0]       wdata_q, wdata_d, rdata_q, rdata_d;

  logic [S_ADDR_WIDTH-1:0] sid_arr   [NREQ];
  logic [AWIDTH-1:0]       addr_arr  [NREQ];
  logic [DWIDTH-1:0]       wdata_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign sid_arr[i]   = req_sid[i*S_ADDR_WIDTH +: S_ADDR_WIDTH];
    assign addr_arr[i]  = req_addr[i*AWIDTH +: AWIDTH];
    assign wdata_arr[i] = req_wdata[i*DWIDTH +: DWIDTH];
  end

  logic [IW-1:0] sel_idx, cand;
  logic          sel_found, sel_bad;

  // Search starts just after the last granted requester and wraps around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last_q) + k) % NREQ);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Unknown slave or a word write that is not 4-byte aligned never reaches the master.
  assign sel_bad = (int'(sid_arr[sel_idx]) >= NSLAVES) ||
                   (req_rw[sel_idx] && (addr_arr[sel_idx][1:0] != 2'b00));

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    rw_d      = rw_q;
    sid_d     = sid_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = '0;
    rsp_valid = '0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    m_start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rst && sel_found) begin
          req_ready[sel_idx] = 1'b1;
          grant_d = sel_idx;
          rw_d    = req_rw[sel_idx];
          sid_d   = sid_arr[sel_idx];
          addr_d  = addr_arr[sel_idx];
          wdata_d = wdata_arr[sel_idx];
          rdata_d = '0;
          err_d   = sel_bad;
          state_d = sel_bad ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        m_start = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // m_done takes priority over a timeout expiring in the same cycle.
        if (m_done) begin
          rdata_d = rw_q ? '0 : m_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid[grant_q] = 1'b1;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
        last_d    = grant_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IW'(NREQ - 1);
      grant_q <= '0;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      sid_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      sid_q   <= sid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign m_rw    = rw_q;
  assign m_sid   = sid_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_spi_2_req_sched.sv
// Directed testbench for spi_2_req_sched: arbitration, handshake, errors, timeout, reset.
module tb_spi_2_req_sched;
  localparam int NREQ = 3;
  localparam int SW   = 2;
  localparam int DW   = 32;
  localparam int AW   = 12;
  localparam int TO   = 1023;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [NREQ-1:0]      req_valid, req_ready, req_rw, rsp_valid;
  logic [NREQ*SW-1:0]   req_sid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [DW-1:0]        rsp_rdata, m_wdata, m_rdata;
  logic                 rsp_err, m_start, m_rw, m_done, busy;
  logic [SW-1:0]        m_sid;
  logic [AW-1:0]        m_addr;

  logic [NREQ-1:0]      d3_req_valid, d3_req_ready, d3_req_rw, d3_rsp_valid;
  logic [NREQ*SW-1:0]   d3_req_sid;
  logic [NREQ*AW-1:0]   d3_req_addr;
  logic [NREQ*DW-1:0]   d3_req_wdata;
  logic [DW-1:0]        d3_rsp_rdata, d3_m_wdata, d3_m_rdata;
  logic                 d3_rsp_err, d3_m_start, d3_m_rw, d3_m_done, d3_busy;
  logic [SW-1:0]        d3_m_sid;
  logic [AW-1:0]        d3_m_addr;

  int checks = 0;
  int failures = 0;

  spi_2_req_sched #(.NREQ(NREQ), .NSLAVES(4), .DWIDTH(DW), .AWIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_sid(req_sid), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .m_start(m_start), .m_rw(m_rw), .m_sid(m_sid),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_done(m_done), .m_rdata(m_rdata), .busy(busy)
  );

  spi_2_req_sched #(.NREQ(NREQ), .NSLAVES(3), .DWIDTH(DW), .AWIDTH(AW), .TIMEOUT(TO)) dut3 (
    .clk(clk), .rst(rst), .req_valid(d3_req_valid), .req_ready(d3_req_ready), .req_rw(d3_req_rw),
    .req_sid(d3_req_sid), .req_addr(d3_req_addr), .req_wdata(d3_req_wdata),
    .rsp_valid(d3_rsp_valid), .rsp_rdata(d3_rsp_rdata), .rsp_err(d3_rsp_err),
    .m_start(d3_m_start), .m_rw(d3_m_rw), .m_sid(d3_m_sid), .m_addr(d3_m_addr),
    .m_wdata(d3_m_wdata), .m_done(d3_m_done), .m_rdata(d3_m_rdata), .busy(d3_busy)
  );

  task automatic set_req(input int i, input logic rw, input logic [SW-1:0] sid,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    req_rw[i] = rw;
    req_sid[i*SW +: SW] = sid;
    req_addr[i*AW +: AW] = addr;
    req_wdata[i*DW +: DW] = wd;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req_valid = '0; m_done = 1'b0; m_rdata = '0;
    d3_req_valid = '0; d3_m_done = 1'b0; d3_m_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 3'b111;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL reset_req_ready got=%b exp=000", req_ready); end
    checks++; if (rsp_valid !== 3'b000) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=000", rsp_valid); end
    checks++; if (m_start !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_start_busy got=%b%b exp=00", m_start, busy); end
    checks++; if ({m_rw, m_sid, m_addr, m_wdata} !== '0) begin failures++; $display("FAIL reset_cmd got=%b/%h/%h/%h exp=0", m_rw, m_sid, m_addr, m_wdata); end
    checks++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp got=%h/%b exp=0/0", rsp_rdata, rsp_err); end
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    set_req(0, 1'b0, 2'd2, 12'h010, 32'h0);
    @(negedge clk); req_valid = 3'b001; #1;
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL rd_ready got=%b exp=001", req_ready); end
    @(negedge clk); req_valid = 3'b000; #1;
    checks++; if (m_start !== 1'b1) begin failures++; $display("FAIL rd_start got=%b exp=1", m_start); end
    checks++; if (m_sid !== 2'd2 || m_addr !== 12'h010 || m_rw !== 1'b0) begin failures++; $display("FAIL rd_cmd got=%h/%h/%b exp=2/010/0", m_sid, m_addr, m_rw); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      checks++; if (m_start !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL rd_wait got start=%b busy=%b exp=0/1", m_start, busy); end
    end
    @(negedge clk); m_done = 1'b1; m_rdata = 32'hDEADBEEF; #1;
    checks++; if (rsp_valid !== 3'b000) begin failures++; $display("FAIL rd_early_rsp got=%b exp=000", rsp_valid); end
    @(negedge clk); m_done = 1'b0; m_rdata = '0; #1;
    checks++; if (rsp_valid !== 3'b001) begin failures++; $display("FAIL rd_rsp_valid got=%b exp=001", rsp_valid); end
    checks++; if (rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) begin failures++; $display("FAIL rd_rsp got=%h/%b exp=deadbeef/0", rsp_rdata, rsp_err); end
    checks++; if (m_sid !== 2'd2 || m_addr !== 12'h010) begin failures++; $display("FAIL rd_cmd_hold got=%h/%h exp=2/010", m_sid, m_addr); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 3'b000 || busy !== 1'b0) begin failures++; $display("FAIL rd_idle got=%b/%b exp=000/0", rsp_valid, busy); end
  endtask

  task automatic test_write();
    set_req(1, 1'b1, 2'd1, 12'h100, 32'hCAFEF00D);
    @(negedge clk); req_valid = 3'b010; #1;
    checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL wr_ready got=%b exp=010", req_ready); end
    @(negedge clk); req_valid = 3'b000; #1;
    checks++; if (m_start !== 1'b1 || m_rw !== 1'b1) begin failures++; $display("FAIL wr_start got=%b/%b exp=1/1", m_start, m_rw); end
    checks++; if (m_wdata !== 32'hCAFEF00D || m_addr !== 12'h100 || m_sid !== 2'd1) begin failures++; $display("FAIL wr_cmd got=%h/%h/%h exp=cafef00d/100/1", m_wdata, m_addr, m_sid); end
    @(negedge clk); m_done = 1'b1; m_rdata = 32'h55555555;
    @(negedge clk); m_done = 1'b0; m_rdata = '0; #1;
    checks++; if (rsp_valid !== 3'b010 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin failures++; $display("FAIL wr_rsp got=%b/%h/%b exp=010/0/0", rsp_valid, rsp_rdata, rsp_err); end
  endtask

  task automatic test_round_robin();
    int rem [NREQ];
    int k, resp, starts, cyc, acc_cyc, cur_g;
    bit outstanding, done_next;
    logic [NREQ-1:0] exp_g;
    logic [DW-1:0] exp_d;
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, 1'b0, SW'(i), AW'(i * 4), 32'h0);
      rem[i] = 4;
    end
    k = 0; resp = 0; starts = 0; cyc = 0; acc_cyc = 0; cur_g = 0;
    outstanding = 1'b0; done_next = 1'b0;
    while (resp < 12 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NREQ; i++) req_valid[i] = (rem[i] > 0);
      m_done = done_next;
      m_rdata = done_next ? 32'hA0000000 + DW'(resp) : '0;
      done_next = 1'b0;
      #1;
      if (req_ready != '0) begin
        exp_g = NREQ'(1 << (k % NREQ));
        checks++; if (req_ready !== exp_g) begin failures++; $display("FAIL rr_grant txn=%0d got=%b exp=%b", k, req_ready, exp_g); end
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) rem[i]--;
        cur_g = k % NREQ; acc_cyc = cyc; k++;
      end
      if (m_start) begin
        checks++; if (outstanding) begin failures++; $display("FAIL rr_overlap got=start_while_busy exp=none"); end
        outstanding = 1'b1; starts++; done_next = 1'b1;
      end
      if (rsp_valid != '0) begin
        exp_g = NREQ'(1 << cur_g);
        exp_d = 32'hA0000000 + DW'(resp);
        checks++; if (rsp_valid !== exp_g || rsp_rdata !== exp_d) begin failures++; $display("FAIL rr_rsp got=%b/%h exp=%b/%h", rsp_valid, rsp_rdata, exp_g, exp_d); end
        checks++; if (cyc - acc_cyc != 3) begin failures++; $display("FAIL rr_latency got=%0d exp=3", cyc - acc_cyc); end
        outstanding = 1'b0; resp++;
      end
    end
    m_done = 1'b0; m_rdata = '0; req_valid = '0;
    checks++; if (resp != 12 || starts != 12 || k != 12) begin failures++; $display("FAIL rr_counts got=rsp%0d/start%0d/grant%0d exp=12/12/12", resp, starts, k); end
  endtask

  task automatic test_misaligned();
    set_req(1, 1'b1, 2'd1, 12'h003, 32'h11111111);
    @(negedge clk); req_valid = 3'b010; #1;
    checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL mis_ready got=%b exp=010", req_ready); end
    @(negedge clk); req_valid = 3'b000; #1;
    checks++; if (m_start !== 1'b0) begin failures++; $display("FAIL mis_no_start got=%b exp=0", m_start); end
    checks++; if (rsp_valid !== 3'b010 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin failures++; $display("FAIL mis_rsp got=%b/%b/%h exp=010/1/0", rsp_valid, rsp_err, rsp_rdata); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || m_start !== 1'b0) begin failures++; $display("FAIL mis_idle got=%b/%b exp=0/0", busy, m_start); end
    set_req(1, 1'b0, 2'd1, 12'h003, 32'h0);
    req_valid = 3'b010;
    @(negedge clk); req_valid = 3'b000; #1;
    checks++; if (m_start !== 1'b1) begin failures++; $display("FAIL mis_read_start got=%b exp=1", m_start); end
    @(negedge clk); m_done = 1'b1; m_rdata = 32'h0000ABCD;
    @(negedge clk); m_done = 1'b0; m_rdata = '0; #1;
    checks++; if (rsp_valid !== 3'b010 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0000ABCD) begin failures++; $display("FAIL mis_read_rsp got=%b/%b/%h exp=010/0/0000abcd", rsp_valid, rsp_err, rsp_rdata); end
  endtask

  task automatic test_bad_sid();
    d3_req_rw[0] = 1'b0; d3_req_sid[1:0] = 2'd3; d3_req_addr[11:0] = 12'h010;
    @(negedge clk); d3_req_valid = 3'b001; #1;
    checks++; if (d3_req_ready !== 3'b001) begin failures++; $display("FAIL sid_ready got=%b exp=001", d3_req_ready); end
    @(negedge clk); d3_req_valid = 3'b000; #1;
    checks++; if (d3_m_start !== 1'b0) begin failures++; $display("FAIL sid_no_start got=%b exp=0", d3_m_start); end
    checks++; if (d3_rsp_valid !== 3'b001 || d3_rsp_err !== 1'b1 || d3_rsp_rdata !== 32'h0) begin failures++; $display("FAIL sid_rsp got=%b/%b/%h exp=001/1/0", d3_rsp_valid, d3_rsp_err, d3_rsp_rdata); end
    d3_req_sid[1:0] = 2'd2;
    @(negedge clk); d3_req_valid = 3'b001;
    @(negedge clk); d3_req_valid = 3'b000; #1;
    checks++; if (d3_m_start !== 1'b1 || d3_m_sid !== 2'd2) begin failures++; $display("FAIL sid2_start got=%b/%h exp=1/2", d3_m_start, d3_m_sid); end
    @(negedge clk); d3_m_done = 1'b1; d3_m_rdata = 32'h0BADF00D;
    @(negedge clk); d3_m_done = 1'b0; d3_m_rdata = '0; #1;
    checks++; if (d3_rsp_valid !== 3'b001 || d3_rsp_err !== 1'b0 || d3_rsp_rdata !== 32'h0BADF00D) begin failures++; $display("FAIL sid2_rsp got=%b/%b/%h exp=001/0/0badf00d", d3_rsp_valid, d3_rsp_err, d3_rsp_rdata); end
  endtask

  task automatic test_timeout();
    int n;
    set_req(2, 1'b0, 2'd0, 12'h020, 32'h0);
    @(negedge clk); req_valid = 3'b100; #1;
    checks++; if (req_ready !== 3'b100) begin failures++; $display("FAIL to_ready got=%b exp=100", req_ready); end
    @(negedge clk); req_valid = 3'b000; #1;
    checks++; if (m_start !== 1'b1) begin failures++; $display("FAIL to_start got=%b exp=1", m_start); end
    n = 0;
    do begin
      @(negedge clk); n++; #1;
    end while (rsp_valid == '0 && n < TO + 50);
    checks++; if (n != TO + 1) begin failures++; $display("FAIL to_cycles got=%0d exp=%0d", n - 1, TO); end
    checks++; if (rsp_valid !== 3'b100 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin failures++; $display("FAIL to_rsp got=%b/%b/%h exp=100/1/0", rsp_valid, rsp_err, rsp_rdata); end
    set_req(0, 1'b0, 2'd1, 12'h024, 32'h0);
    @(negedge clk); req_valid = 3'b001; #1;
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL to_next_ready got=%b exp=001", req_ready); end
    @(negedge clk); req_valid = 3'b000;
    @(negedge clk); m_done = 1'b1; m_rdata = 32'h600DF00D;
    @(negedge clk); m_done = 1'b0; m_rdata = '0; #1;
    checks++; if (rsp_valid !== 3'b001 || rsp_err !== 1'b0 || rsp_rdata !== 32'h600DF00D) begin failures++; $display("FAIL to_next_rsp got=%b/%b/%h exp=001/0/600df00d", rsp_valid, rsp_err, rsp_rdata); end
  endtask

  task automatic test_done_at_timeout();
    int n;
    set_req(1, 1'b0, 2'd3, 12'h030, 32'h0);
    @(negedge clk); req_valid = 3'b010; #1;
    checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL dt_ready got=%b exp=010", req_ready); end
    @(negedge clk); req_valid = 3'b000;
    n = 0;
    do begin
      @(negedge clk); n++;
      m_done = (n == TO);
      m_rdata = (n == TO) ? 32'h12345678 : '0;
      #1;
    end while (rsp_valid == '0 && n < TO + 50);
    m_done = 1'b0; m_rdata = '0;
    checks++; if (n != TO + 1) begin failures++; $display("FAIL dt_cycles got=%0d exp=%0d", n, TO + 1); end
    checks++; if (rsp_valid !== 3'b010 || rsp_err !== 1'b0 || rsp_rdata !== 32'h12345678) begin failures++; $display("FAIL dt_rsp got=%b/%b/%h exp=010/0/12345678", rsp_valid, rsp_err, rsp_rdata); end
  endtask

  task automatic test_reset_in_wait();
    set_req(0, 1'b0, 2'd1, 12'h040, 32'h0);
    @(negedge clk); req_valid = 3'b001;
    @(negedge clk); req_valid = 3'b000;
    @(negedge clk); m_done = 1'b1; m_rdata = 32'h0;
    @(negedge clk); m_done = 1'b0; #1;
    checks++; if (rsp_valid !== 3'b001) begin failures++; $display("FAIL rw_setup got=%b exp=001", rsp_valid); end
    set_req(2, 1'b1, 2'd2, 12'h044, 32'h77777777);
    @(negedge clk); req_valid = 3'b100; #1;
    checks++; if (req_ready !== 3'b100) begin failures++; $display("FAIL rw_ready got=%b exp=100", req_ready); end
    @(negedge clk); req_valid = 3'b000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; m_done = 1'b1; m_rdata = 32'hFFFFFFFF; #1;
    checks++; if (busy !== 1'b0 || rsp_valid !== 3'b000 || m_start !== 1'b0) begin failures++; $display("FAIL rw_after_rst got=%b/%b/%b exp=0/000/0", busy, rsp_valid, m_start); end
    checks++; if ({m_rw, m_sid, m_addr, m_wdata} !== '0) begin failures++; $display("FAIL rw_cmd_clr got=%b/%h/%h/%h exp=0", m_rw, m_sid, m_addr, m_wdata); end
    @(negedge clk); m_done = 1'b0; m_rdata = '0; #1;
    checks++; if (rsp_valid !== 3'b000 || busy !== 1'b0) begin failures++; $display("FAIL rw_late_done got=%b/%b exp=000/0", rsp_valid, busy); end
    req_valid = 3'b111; #1;
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL rw_regrant got=%b exp=001", req_ready); end
    @(negedge clk); req_valid = 3'b000;
    @(negedge clk); m_done = 1'b1; m_rdata = 32'h00C0FFEE;
    @(negedge clk); m_done = 1'b0; m_rdata = '0; #1;
    checks++; if (rsp_valid !== 3'b001 || rsp_rdata !== 32'h00C0FFEE) begin failures++; $display("FAIL rw_final_rsp got=%b/%h exp=001/00c0ffee", rsp_valid, rsp_rdata); end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_rw = '0; req_sid = '0; req_addr = '0; req_wdata = '0;
    m_done = 1'b0; m_rdata = '0;
    d3_req_valid = '0; d3_req_rw = '0; d3_req_sid = '0; d3_req_addr = '0; d3_req_wdata = '0;
    d3_m_done = 1'b0; d3_m_rdata = '0;
    test_reset();
    test_single_read();
    test_write();
    test_round_robin();
    test_misaligned();
    test_bad_sid();
    test_timeout();
    test_done_at_timeout();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_2_req_sched.md
Name: spi_2_req_sched

Overview:
Round-robin scheduler that shares the single SPI master engine between NREQ on-chip requesters. Each requester issues one memory transaction at a time: read or write, target slave id, byte address and write data. The scheduler grants one requester, sequences the master through a start/done handshake and returns read data or an error to the granted requester. It sits between the requester ports and the SPI master core, using the spi_2_pkg widths.

Parameters:
NREQ, 3, number of requesters (>=2)
NSLAVES, 4, number of SPI slaves
S_ADDR_WIDTH, $clog2(NSLAVES), slave id width
DWIDTH, 32, data width
AWIDTH, 12, byte address width
TIMEOUT, 1023, max cycles to wait for m_done before flagging an error

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester transaction request
req_ready  out  NREQ  one-hot, single-cycle acceptance pulse
req_rw  in  NREQ  1=write, 0=read
req_sid  in  NREQ*S_ADDR_WIDTH  packed slave ids, requester i at [i*S_ADDR_WIDTH +: S_ADDR_WIDTH]
req_addr  in  NREQ*AWIDTH  packed byte addresses
req_wdata  in  NREQ*DWIDTH  packed write data
rsp_valid  out  NREQ  one-hot, single-cycle response pulse
rsp_rdata  out  DWIDTH  read data, valid with rsp_valid (0 for writes and errors)
rsp_err  out  1  error flag, valid with rsp_valid
m_start  out  1  single-cycle start pulse to the SPI master
m_rw, m_sid, m_addr, m_wdata  out  1/S_ADDR_WIDTH/AWIDTH/DWIDTH  command fields, held stable from m_start until m_done
m_done  in  1  single-cycle completion pulse from the SPI master
m_rdata  in  DWIDTH  master read data, valid with m_done
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=1 at a clock edge) overrides everything, including a transfer in progress:
  - state to IDLE; all outputs 0.
  - last-grant pointer to NREQ-1, so requester 0 has first priority.
  - timeout counter to 0.
  - An m_done arriving later is ignored because it is only sampled in WAIT.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, when any req_valid is high:
  - Select g = first i with req_valid[i]=1, searching from (last+1) mod NREQ upward with wrap.
  - Assert req_ready[g] combinationally in that cycle.
  - Latch rw, sid, addr and wdata of requester g into the command registers.
  - Check the request:
    - If sid>=NSLAVES, or rw=1 and addr[1:0]!=0 (misaligned word write), set err=1 and go to RESP without touching the master.
    - Otherwise go to ISSUE.
- IDLE with no req_valid: stay.
- ISSUE: m_start=1 for exactly one cycle; clear the counter; go to WAIT.
- WAIT:
  - Counter increments every cycle.
  - On m_done=1: capture m_rdata if rw=0 (else 0); err=0; go to RESP.
  - If counter reaches TIMEOUT with no m_done: err=1, rdata=0, go to RESP.
  - If m_done and the timeout coincide in the same cycle, m_done wins and err=0.
- RESP:
  - rsp_valid[g]=1 for one cycle, with rsp_rdata and rsp_err driven.
  - last=g; return to IDLE.
  - A new grant can occur on the next cycle.
- m_* command outputs are register-driven and hold their value until the next grant.
- Latency:
  - Accept at cycle T, m_start at T+1.
  - m_done at cycle D gives rsp_valid at D+1.
  - Minimum is accept-to-response 3 cycles when m_done comes the cycle after m_start.
  - An error at grant gives rsp_valid at T+1.
- Requester rules:
  - A requester keeps req_* stable until req_ready.
  - A requester may deassert req_valid before being granted; this has no effect.
  - req_valid seen outside IDLE is ignored.
  - Only one transaction is outstanding system-wide.
- Fairness: with all NREQ requesters continuously valid, grants rotate 0,1,…,NREQ-1,0. No requester waits more than NREQ-1 other transactions.

Test Plan:
- Reset then single read: req_valid[0], sid=2, addr=0x010; master returns m_done with m_rdata=0xDEADBEEF 5 cycles after m_start -> req_ready[0] at T, m_start at T+1 with m_sid=2, m_addr=0x010, rsp_valid=3'b001 with rdata 0xDEADBEEF and err=0.
- All three requesters valid continuously, each with 4 transactions -> grant order 0,1,2,0,1,2,…; exactly one m_start per transaction; no overlap.
- Write with addr=0x003 -> no m_start; rsp_valid at T+1 with err=1, rdata=0. Then with NSLAVES=3, sid=3 -> same error response.
- Master never asserts m_done -> rsp_err=1 exactly TIMEOUT cycles after entering WAIT; the next request is served normally afterwards.
- m_done in the same cycle as the timeout -> err=0 and rdata captured.
- rst asserted in WAIT, followed by a late m_done -> all outputs 0; no rsp_valid; the next grant goes to requester 0 even if requester 2 was last granted.
